// File: rtl/event_flasher_pkg.sv
// Shared types and elaboration helpers for the event flasher.
package event_flasher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } flash_state_t;

   // Width able to hold max(on_c, off_c) - 1; never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned on_c,
                                               input int unsigned off_c);
      int unsigned m;
      m = (on_c > off_c) ? on_c : off_c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic bit params_ok(input int unsigned on_c,
                                    input int unsigned off_c,
                                    input int unsigned max_p);
      return (on_c >= 1) && (off_c >= 1) && (max_p >= 1);
   endfunction

endpackage

// File: rtl/event_flasher_cycle_timer.sv
// Loadable down-counter shared by the ON and OFF phases of a flash.
module event_flasher_cycle_timer
   import event_flasher_pkg::*;
#(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/event_flasher.sv
// Turns single-cycle event pulses into fixed-length LED flashes, queueing extras.
module event_flasher
   import event_flasher_pkg::*;
#(
   parameter int unsigned ON_CYCLES   = 4,
   parameter int unsigned OFF_CYCLES  = 2,
   parameter int unsigned MAX_PENDING = 3,
   parameter int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pulse,
   output logic          led,
   output logic          busy,
   output logic [PW-1:0] pending,
   output logic          overflow
);

   localparam int unsigned TW = timer_width(ON_CYCLES, OFF_CYCLES);

   flash_state_t  state_q, state_d;
   logic [PW-1:0] pending_q, pending_d;
   logic          overflow_q, overflow_d;
   logic          tmr_load, tmr_dec, tmr_zero, enq;
   logic [TW-1:0] tmr_load_val;

   event_flasher_cycle_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      overflow_d   = overflow_q;
      tmr_load     = 1'b0;
      tmr_load_val = TW'(ON_CYCLES - 1);
      tmr_dec      = 1'b0;
      enq          = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pulse) begin
               state_d  = ON;
               tmr_load = 1'b1;
            end
         end
         ON: begin
            enq = pulse;
            if (tmr_zero) begin
               state_d      = OFF;
               tmr_load     = 1'b1;
               tmr_load_val = TW'(OFF_CYCLES - 1);
            end else begin
               tmr_dec = 1'b1;
            end
         end
         OFF: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
               enq     = pulse;
            end else if ((pending_q != '0) || pulse) begin
               // A pulse here either starts the flash itself or replaces the consumed entry.
               state_d  = ON;
               tmr_load = 1'b1;
               if ((pending_q != '0) && !pulse) begin
                  pending_d = pending_q - PW'(1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (enq) begin
         if (pending_q == PW'(MAX_PENDING)) begin
            overflow_d = 1'b1;
         end else begin
            pending_d = pending_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign led      = (state_q == ON);
   assign busy     = (state_q != IDLE);
   assign pending  = pending_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_event_flasher.sv
// Directed bench for event_flasher: flash-age reference model plus literal spot checks.
module tb_event_flasher;

   localparam int ON   = 4;
   localparam int OFF  = 2;
   localparam int MAXP = 3;
   localparam int PW   = $clog2(MAXP + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          pulse;
   logic          led, busy, overflow;
   logic [PW-1:0] pending;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Model: age = cycles into the current ON+OFF period, -1 when idle.
   int m_age  = -1;
   int m_pend = 0;
   int m_ovf  = 0;

   event_flasher #(
      .ON_CYCLES   (ON),
      .OFF_CYCLES  (OFF),
      .MAX_PENDING (MAXP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pulse    (pulse),
      .led      (led),
      .busy     (busy),
      .pending  (pending),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         m_age  = -1;
         m_pend = 0;
         m_ovf  = 0;
      end else if (m_age < 0) begin
         if (pulse) m_age = 0;
      end else if (m_age == ON + OFF - 1) begin
         if (m_pend > 0 || pulse) begin
            m_age = 0;
            if (m_pend > 0 && !pulse) m_pend--;
         end else begin
            m_age = -1;
         end
      end else begin
         m_age++;
         if (pulse) begin
            if (m_pend < MAXP) m_pend++;
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_led", led, (m_age >= 0 && m_age < ON) ? 1 : 0);
         check("model_busy", busy, (m_age >= 0) ? 1 : 0);
         check("model_pending", pending, m_pend);
         check("model_overflow", overflow, m_ovf);
      end
   end

   task automatic tick(input logic p, input logic r);
      pulse = p;
      reset = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      pulse = 1'b1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Reset held with pulse high
      for (int k = 0; k < 2; k++) begin
         check("t1_led", led, 0);
         check("t1_busy", busy, 0);
         check("t1_pending", pending, 0);
         check("t1_overflow", overflow, 0);
         if (k == 0) tick(1'b1, 1'b0);
      end

      // Single pulse
      tick(1'b1, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         check("t2_led", led, (k <= 4) ? 1 : 0);
         check("t2_busy", busy, (k <= 6) ? 1 : 0);
         tick(1'b0, 1'b1);
      end

      // Second pulse queued mid-flash
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      for (int k = 3; k <= 13; k++) begin
         check("t3_pending", pending, (k < 7) ? 1 : 0);
         check("t3_led", led, (k <= 4 || (k >= 7 && k <= 10)) ? 1 : 0);
         tick(1'b0, 1'b1);
      end

      // Pulse held six cycles: saturation and overflow
      cnt = 0;
      for (int k = 0; k <= 5; k++) begin
         check("t4_pending", pending, (k == 0) ? 0 : ((k - 1 > 3) ? 3 : k - 1));
         check("t4_overflow", overflow, (k >= 5) ? 1 : 0);
         cnt += int'(led);
         tick(1'b1, 1'b1);
      end
      for (int k = 0; k < 30; k++) begin
         cnt += int'(led);
         tick(1'b0, 1'b1);
      end
      check("t4_led_cycles", cnt, 16);
      check("t4_overflow_sticky", overflow, 1);
      check("t4_idle", busy, 0);
      tick(1'b0, 1'b0);
      check("t4_overflow_cleared", overflow, 0);

      // Pulse on last OFF cycle with one pending
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      check("t5_led", led, 1);
      check("t5_pending", pending, 1);
      cnt = 0;
      for (int k = 7; k <= 26; k++) begin
         cnt += int'(led);
         tick(1'b0, 1'b1);
      end
      check("t5_led_cycles", cnt, 8);
      check("t5_idle", busy, 0);

      // Reset mid-flash with two pending
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("t6_pending_pre", pending, 2);
      check("t6_led_pre", led, 1);
      tick(1'b0, 1'b0);
      check("t6_led", led, 0);
      check("t6_pending", pending, 0);
      check("t6_busy", busy, 0);
      tick(1'b1, 1'b1);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         cnt += int'(led);
         tick(1'b0, 1'b1);
      end
      check("t6_led_cycles", cnt, 4);
      check("t6_idle", busy, 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
